// File: rtl/bias_bank_loadable.sv
// Purpose: run-time loadable per-group bias add with saturation, between adder trees and requant.
// Latency: 1 cycle from in_valid&in_ready to out_valid; a full load takes N_GROUPS*N_adder_tree words.
// Backpressure: in_ready only while a complete bank is held, ld_ready only while loading; no output backpressure.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ld_restart          restart loading at word 0 (drops that cycle's ld_valid word)
//   ld_valid/ld_data    serial bias words, word k -> group k/N_adder_tree, lane k%N_adder_tree
//   ld_ready            high while loading
//   loaded              high once every bias of the bank has been written
//   in_valid/in_group   adder-tree result and the group whose biases apply
//   in_data             lane i at [W*(i+1)-1:W*i], signed
//   in_ready            high while a complete bank is held
//   out_valid/out_data  biased, saturated lanes, same packing; held while out_valid=0
//   out_sat             per-lane saturation flags for the current result
//   group_err           in_group was out of range (bias forced to 0) for the current result
// Optional: define BIAS_BANK_RELU_EN to clamp negative lanes to 0 after saturation,
//   adding input relu_bypass which skips the clamp for that accept.
module bias_bank_loadable #(
    parameter int N_adder_tree = 16,
    parameter int W            = 18,
    parameter int N_GROUPS     = 4,
    parameter int GW           = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_restart,
    input  logic                      ld_valid,
    input  logic [W-1:0]              ld_data,
    output logic                      ld_ready,
    output logic                      loaded,
    input  logic                      in_valid,
    input  logic [GW-1:0]             in_group,
    input  logic [N_adder_tree*W-1:0] in_data,
`ifdef BIAS_BANK_RELU_EN
    input  logic                      relu_bypass,
`endif
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic [N_adder_tree-1:0]   out_sat,
    output logic                      group_err
);
    localparam int TOTAL = N_GROUPS * N_adder_tree;
    localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  bias [TOTAL];
    logic          ld_we;
    logic          ld_last;
    logic          accept;

    // ---------------- load control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    assign ld_last = (cnt == CW'(TOTAL - 1));

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        in_ready  = 1'b0;
        loaded    = 1'b0;
        case (state)
            // Leaving reset (or a restart) always heads straight into loading.
            EMPTY: state_nxt = LOADING;
            LOADING: begin
                ld_ready = 1'b1;
                if (!ld_restart && ld_valid && ld_last) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                in_ready = 1'b1;
                loaded   = 1'b1;
                if (ld_restart) begin
                    state_nxt = LOADING;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // A restart wins over a same-cycle word, so that word is dropped.
    assign ld_we = ld_ready && ld_valid && !ld_restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld_restart) begin
            cnt <= '0;
        end else if (ld_we) begin
            cnt <= ld_last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TOTAL; k++) begin
                bias[k] <= '0;
            end
        end else if (ld_we) begin
            bias[cnt] <= ld_data;
        end
    end

    // ---------------- bias add / saturate ----------------
    logic                      grp_ok;
    int                        gsel;
    logic [CW-1:0]             ridx;
    logic [W-1:0]              lane_d, lane_b, lane_r;
    logic [W:0]                lane_s;
    logic                      lane_sat;
    logic [N_adder_tree*W-1:0] sum_dat;
    logic [N_adder_tree-1:0]   sum_sat;

    always_comb begin
        grp_ok   = ({1'b0, in_group} < (GW+1)'(N_GROUPS));
        gsel     = grp_ok ? int'(in_group) : 0;
        ridx     = '0;
        lane_d   = '0;
        lane_b   = '0;
        lane_s   = '0;
        lane_r   = '0;
        lane_sat = 1'b0;
        sum_dat  = '0;
        sum_sat  = '0;
        for (int i = 0; i < N_adder_tree; i++) begin
            ridx   = CW'(gsel * N_adder_tree + i);
            lane_d = in_data[i*W +: W];
            lane_b = grp_ok ? bias[ridx] : '0;
            // Sign-extend both to W+1 bits; the top two bits of the sum expose overflow.
            lane_s = {lane_d[W-1], lane_d} + {lane_b[W-1], lane_b};
            case (lane_s[W:W-1])
                2'b01: begin
                    lane_r   = POS_MAX;
                    lane_sat = 1'b1;
                end
                2'b10: begin
                    lane_r   = NEG_MIN;
                    lane_sat = 1'b1;
                end
                default: begin
                    lane_r   = lane_s[W-1:0];
                    lane_sat = 1'b0;
                end
            endcase
`ifdef BIAS_BANK_RELU_EN
            // Clamp after saturation so out_sat still reflects the pre-ReLU overflow.
            if (!relu_bypass && lane_r[W-1]) begin
                lane_r = '0;
            end
`endif
            sum_dat[i*W +: W] = lane_r;
            sum_sat[i]        = lane_sat;
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
            group_err <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_data  <= sum_dat;
                out_sat   <= sum_sat;
                group_err <= !grp_ok;
            end
        end
    end

endmodule
